reg_file_param: RTL

Parametrised multi-port register file for the microprocessor datapath: the next generation of the 32×8 file. It adds configurable width and depth, a configurable number of read ports, optional hard-wired zero register and write-to-read bypass, and a selectable combinational or registered read. It also provides a sequenced bulk clear with a busy indication. It sits between the decoder (addresses, enables) and the ALU/writeback path (read data, write data).

---
 rtl/rf_pkg.sv | 19 +
 rtl/reg_file_param_if.sv | 29 ++
 rtl/rf_clear_seq.sv | 62 ++++++
 rtl/reg_file_param.sv | 96 +++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the parametrised register file.
// Covers the clear-sequencer state type, default geometry and port-slice arithmetic.
package rf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRD    = 2;

    // Low bit of port `port` inside a flattened multi-port bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Decoder-side bus of the register file: read/write addresses, data, enables and clear status.
// The decoder drives the master modport and the register file implements the slave modport.
interface reg_file_param_if #(
    parameter int DATA_W = rf_pkg::DEF_DATA_W,
    parameter int ADDR_W = rf_pkg::DEF_ADDR_W,
    parameter int NRD    = rf_pkg::DEF_NRD
);

    logic [NRD*ADDR_W-1:0] ra;
    logic                  re;
    logic [NRD*DATA_W-1:0] rd;
    logic [ADDR_W-1:0]     wa;
    logic [DATA_W-1:0]     wd;
    logic                  we;
    logic                  clr_req;
    logic                  busy;
    logic                  wr_drop;

    modport master (
        output ra, re, wa, wd, we, clr_req,
        input  rd, busy, wr_drop
    );

    modport slave (
        input  ra, re, wa, wd, we, clr_req,
        output rd, busy, wr_drop
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Bulk-clear sequencer: sweeps every register to zero, one per clock, and reports busy.
// Also flags writes that arrive while the sweep owns the storage array.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              we,
    output logic              busy,
    output logic              wr_drop,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && busy;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // busy mirrors the CLEAR state, so it doubles as the sweep write strobe.
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised multi-port register file with optional zero register, write bypass,
// combinational or registered reads, and a sequenced bulk clear.
module reg_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int R0_ZERO  = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input logic             clk,
    input logic             rst_n,
    reg_file_param_if.slave bus
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic              busy;
    logic              wr_drop;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .we       (bus.we),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop;

    // A write qualifies only outside a clear and never targets a hard-wired zero register.
    assign wr_ok = bus.we && !busy && !((R0_ZERO != 0) && (bus.wa == '0));

    // NOTE: storage is a flop array with async reset so every entry zeroes at once; no SRAM macro fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_val;

        assign addr = bus.ra[slice_lo(p, ADDR_W) +: ADDR_W];

        // NOTE: rd_val gets a default first so no path through the block infers a latch.
        always_comb begin
            rd_val = '0;
            if (!bus.re || busy) begin
                rd_val = '0;
            end else if ((R0_ZERO != 0) && (addr == '0)) begin
                rd_val = '0;
            end else if ((BYPASS != 0) && wr_ok && (bus.wa == addr)) begin
                rd_val = bus.wd;
            end else begin
                rd_val = mem[addr];
            end
        end

        if (READ_REG != 0) begin : g_reg
            logic [DATA_W-1:0] rd_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_val;
                end
            end

            assign bus.rd[slice_lo(p, DATA_W) +: DATA_W] = rd_q;
        end else begin : g_comb
            assign bus.rd[slice_lo(p, DATA_W) +: DATA_W] = rd_val;
        end
    end

endmodule
